// File: rtl/dac_sched_pkg.sv
// Shared types, defaults and frame formatting for the DAC update scheduler.
package dac_sched_pkg;

  localparam int DEF_NCH            = 8;
  localparam int DEF_DW             = 12;
  localparam int DEF_GAP_CYCLES     = 40;
  localparam int DEF_REFRESH_CYCLES = 65536;
  localparam int DEF_LDAC_WIDTH     = 4;
  localparam int DEF_START_TIMEOUT  = 1024;
  localparam int WORD_W             = 16;

  typedef enum logic [2:0] {IDLE, ARB, START, WAIT, GAP, LDAC} state_e;

  // Channel index sits directly above the sample; anything above that is zero.
  function automatic logic [WORD_W-1:0] make_word(input logic [31:0] ch,
                                                  input logic [31:0] data,
                                                  input int          dw);
    logic [31:0] w;
    w = (ch << dw) | data;
    return w[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/dac_update_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational search for the first request at or after
// a registered pointer; the pointer moves past the grant when it is accepted.
module rr_arbiter #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_i,
  input  logic                 adv_i,
  output logic [$clog2(N)-1:0] grant_o,
  output logic                 valid_o,
  output logic [$clog2(N)-1:0] ptr_o
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the nearest request is assigned last.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = ptr_q + IW'(i);
      if (req_i[idx]) begin
        grant_o = idx;
        valid_o = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    ptr_q <= '0;
    else if (adv_i && valid_o)  ptr_q <= grant_o + IW'(1);
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/dac_update_scheduler.sv
// Schedules shadow-register updates onto a shared SPI DAC serializer, refreshes
// idle channels in rotation and pulses ldac_n once a batch of updates drains.
module dac_update_scheduler
  import dac_sched_pkg::*;
#(
  parameter int NCH            = DEF_NCH,
  parameter int DW             = DEF_DW,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
  parameter int LDAC_WIDTH     = DEF_LDAC_WIDTH,
  parameter int START_TIMEOUT  = DEF_START_TIMEOUT
) (
  input  logic                   clk_core,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [$clog2(NCH)-1:0] wr_ch,
  input  logic [DW-1:0]          wr_data,
  output logic                   spi_start,
  output logic [WORD_W-1:0]      spi_word,
  input  logic                   spi_busy,
  input  logic                   spi_done,
  output logic [$clog2(NCH)-1:0] active_ch,
  output logic [NCH-1:0]         pending,
  output logic                   ldac_n,
  output logic                   timeout_err
);

  localparam int CW         = $clog2(NCH);
  localparam bit REFRESH_EN = (REFRESH_CYCLES != 0);
  localparam int RW         = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int TMAX       = (START_TIMEOUT > GAP_CYCLES) ?
                              ((START_TIMEOUT > LDAC_WIDTH) ? START_TIMEOUT : LDAC_WIDTH) :
                              ((GAP_CYCLES > LDAC_WIDTH) ? GAP_CYCLES : LDAC_WIDTH);
  localparam int TW         = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_e              state_q, state_d;
  logic [DW-1:0]       shadow_q [NCH];
  logic [NCH-1:0]      pending_q, pending_d;
  logic [WORD_W-1:0]   spi_word_q;
  logic [CW-1:0]       active_ch_q;
  logic                err_q;
  logic                refresh_q;
  logic                upd_frame_q;
  logic                ldac_due_q;
  logic [TW-1:0]       tmr_q;
  logic [RW-1:0]       rcnt_q;

  logic                do_grant, do_timeout, refresh_fire, frame_done;
  logic [CW-1:0]       grant, rr_ptr;
  logic                grant_valid;
  logic [NCH-1:0]      force_vec, arb_req;

  // A refresh forces the grant onto the pointer's channel.
  assign force_vec = NCH'(1) << rr_ptr;
  assign arb_req   = refresh_q ? force_vec : pending_q;

  rr_arbiter #(.N(NCH)) u_arb (
    .clk     (clk_core),
    .rst     (rst),
    .req_i   (arb_req),
    .adv_i   (do_grant),
    .grant_o (grant),
    .valid_o (grant_valid),
    .ptr_o   (rr_ptr)
  );

  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    do_grant     = 1'b0;
    do_timeout   = 1'b0;
    refresh_fire = 1'b0;
    frame_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          state_d = ARB;
        end else if (REFRESH_EN && rcnt_q == RW'(REFRESH_CYCLES - 1)) begin
          state_d      = ARB;
          refresh_fire = 1'b1;
        end
      end
      ARB: begin
        do_grant = grant_valid;
        state_d  = grant_valid ? START : IDLE;
      end
      START: begin
        if (spi_busy) begin
          state_d = WAIT;
        end else if (tmr_q == TW'(START_TIMEOUT - 1)) begin
          do_timeout = 1'b1;
          state_d    = GAP;
        end
      end
      WAIT: begin
        if (spi_done) begin
          frame_done = 1'b1;
          state_d    = GAP;
        end
      end
      GAP: begin
        if (tmr_q == TW'(GAP_CYCLES - 1)) begin
          if (|pending_q)     state_d = ARB;
          else if (ldac_due_q) state_d = LDAC;
          else                state_d = IDLE;
        end
      end
      LDAC: begin
        if (tmr_q == TW'(LDAC_WIDTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write sets last so a write racing a grant of the same channel keeps it dirty.
  always_comb begin
    pending_d = pending_q;
    if (do_grant)   pending_d[grant]       = 1'b0;
    if (do_timeout) pending_d[active_ch_q] = 1'b1;
    if (wr_en)      pending_d[wr_ch]       = 1'b1;
  end

  // NOTE: the shadow array is reset because its contents are observable
  // through refresh frames; it is small enough to live in flops.
  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) shadow_q[i] <= '0;
    end else if (wr_en) begin
      shadow_q[wr_ch] <= wr_data;
    end
  end

  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      spi_word_q  <= '0;
      active_ch_q <= '0;
      err_q       <= 1'b0;
      refresh_q   <= 1'b0;
      upd_frame_q <= 1'b0;
      ldac_due_q  <= 1'b0;
      tmr_q       <= '0;
      rcnt_q      <= '0;
    end else begin
      pending_q <= pending_d;
      tmr_q     <= (state_d != state_q) ? '0 : tmr_q + TW'(1);

      if (refresh_fire)  refresh_q <= 1'b1;
      else if (do_grant) refresh_q <= 1'b0;

      if (do_grant) begin
        spi_word_q  <= make_word(32'(grant), 32'(shadow_q[grant]), DW);
        active_ch_q <= grant;
        upd_frame_q <= !refresh_q || pending_q[grant];
      end

      if (do_timeout) err_q <= 1'b1;

      if (state_q == LDAC)                ldac_due_q <= 1'b0;
      else if (frame_done && upd_frame_q) ldac_due_q <= 1'b1;

      if (wr_en || do_grant || refresh_fire)      rcnt_q <= '0;
      else if (state_q == IDLE && pending_q == '0) rcnt_q <= rcnt_q + RW'(1);
    end
  end

  assign spi_start   = (state_q == START);
  assign spi_word    = spi_word_q;
  assign active_ch   = active_ch_q;
  assign pending     = pending_q;
  assign ldac_n      = (state_q != LDAC);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Directed bench: a default-parameter instance for update/timeout/reset cases
// and a REFRESH_CYCLES=16 instance for refresh rotation, each with a serializer model.
module tb_dac_update_scheduler;

  localparam int NCH       = 8;
  localparam int DW        = 12;
  localparam int CW        = 3;
  localparam int FRAME_LEN = 16;

  logic clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  logic          rst, rst_r;
  logic          wr_en;
  logic [CW-1:0] wr_ch;
  logic [DW-1:0] wr_data;
  logic          wr_en_r;
  logic [CW-1:0] wr_ch_r;
  logic [DW-1:0] wr_data_r;
  assign wr_en_r   = 1'b0;
  assign wr_ch_r   = '0;
  assign wr_data_r = '0;

  logic [1:0]     st_v, busy_v, done_v, ldn_v, err_v, rst_v;
  logic [15:0]    word_v [2];
  logic [CW-1:0]  ach_v  [2];
  logic [NCH-1:0] pend_v [2];
  assign rst_v = {rst_r, rst};

  bit          resp_en [2];
  int          cnt_v [2]       = '{0, 0};
  bit          prev_st [2]     = '{0, 0};
  int          low_cnt [2]     = '{0, 0};
  int          ldac_pulses [2] = '{0, 0};
  int          ldac_width [2]  = '{0, 0};
  int          frame_n [2]     = '{0, 0};
  logic [15:0] word_log [2][32];
  int          frame_cyc [2][32];
  int          cyc = 0;

  int n_tests = 0;
  int n_fail  = 0;

  dac_update_scheduler dut (
    .clk_core (clk_core), .rst (rst),
    .wr_en (wr_en), .wr_ch (wr_ch), .wr_data (wr_data),
    .spi_start (st_v[0]), .spi_word (word_v[0]),
    .spi_busy (busy_v[0]), .spi_done (done_v[0]),
    .active_ch (ach_v[0]), .pending (pend_v[0]),
    .ldac_n (ldn_v[0]), .timeout_err (err_v[0])
  );

  dac_update_scheduler #(.REFRESH_CYCLES(16)) dut_r (
    .clk_core (clk_core), .rst (rst_r),
    .wr_en (wr_en_r), .wr_ch (wr_ch_r), .wr_data (wr_data_r),
    .spi_start (st_v[1]), .spi_word (word_v[1]),
    .spi_busy (busy_v[1]), .spi_done (done_v[1]),
    .active_ch (ach_v[1]), .pending (pend_v[1]),
    .ldac_n (ldn_v[1]), .timeout_err (err_v[1])
  );

  // Serializer model and monitors, all on the falling edge.
  always @(negedge clk_core) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst_v[k]) begin
        busy_v[k] = 1'b0; done_v[k] = 1'b0; cnt_v[k] = 0;
        prev_st[k] = 1'b0; low_cnt[k] = 0;
      end else begin
        if (st_v[k] && !prev_st[k] && frame_n[k] < 32) begin
          word_log[k][frame_n[k]]  = word_v[k];
          frame_cyc[k][frame_n[k]] = cyc;
          frame_n[k]++;
        end
        prev_st[k] = st_v[k];
        done_v[k]  = 1'b0;
        if (!resp_en[k]) begin
          busy_v[k] = 1'b0;
        end else if (busy_v[k]) begin
          cnt_v[k]--;
          if (cnt_v[k] == 0) begin busy_v[k] = 1'b0; done_v[k] = 1'b1; end
        end else if (st_v[k]) begin
          busy_v[k] = 1'b1; cnt_v[k] = FRAME_LEN;
        end
        if (!ldn_v[k]) begin
          low_cnt[k]++;
        end else if (low_cnt[k] != 0) begin
          ldac_width[k] = low_cnt[k]; ldac_pulses[k]++; low_cnt[k] = 0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_start"}, 32'(st_v[0]), 0);
    check({tag, "_word"}, 32'(word_v[0]), 0);
    check({tag, "_ach"}, 32'(ach_v[0]), 0);
    check({tag, "_pending"}, 32'(pend_v[0]), 0);
    check({tag, "_ldac_n"}, 32'(ldn_v[0]), 1);
    check({tag, "_err"}, 32'(err_v[0]), 0);
  endtask

  task automatic do_reset();
    @(negedge clk_core) rst = 1'b1;
    @(negedge clk_core);
    check_reset_state("reset");
    rst = 1'b0;
  endtask

  task automatic write_ch(input int ch, input int data);
    @(negedge clk_core);
    wr_en = 1'b1; wr_ch = CW'(ch); wr_data = DW'(data);
    @(negedge clk_core);
    wr_en = 1'b0;
  endtask

  task automatic wait_frames(input int k, input int target, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (frame_n[k] >= target) break;
      @(negedge clk_core);
    end
    check(tag, 32'(frame_n[k] >= target), 1);
  endtask

  task automatic wait_pulses(input int target, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (ldac_pulses[0] >= target) break;
      @(negedge clk_core);
    end
    check(tag, 32'(ldac_pulses[0] >= target), 1);
  endtask

  task automatic wait_in_wait(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_core);
      if (busy_v[0] && !st_v[0]) begin found = 1'b1; break; end
    end
    check(tag, 32'(found), 1);
  endtask

  int f0, p0;

  initial begin
    rst = 1'b1; rst_r = 1'b1;
    wr_en = 1'b0; wr_ch = '0; wr_data = '0;
    resp_en[0] = 1'b1; resp_en[1] = 1'b1;
    do_reset();

    // Refresh rotation with no writes.
    @(negedge clk_core) rst_r = 1'b0;
    wait_frames(1, 9, 1000, "refresh_frames");
    for (int i = 0; i < 9; i++)
      check($sformatf("refresh_word%0d", i), 32'(word_log[1][i]), 32'((i % 8) << 12));
    check("refresh_period", 32'(frame_cyc[1][1] - frame_cyc[1][0]), 74);
    check("refresh_no_ldac", 32'(ldac_pulses[1]), 0);
    rst_r = 1'b1;

    // Single write, latency and LDAC pulse.
    f0 = frame_n[0]; p0 = ldac_pulses[0];
    write_ch(5, 'hABC);
    check("w1_pending", 32'(pend_v[0]), 32'h20);
    check("w1_start_c1", 32'(st_v[0]), 0);
    @(negedge clk_core);
    check("w1_start_c2", 32'(st_v[0]), 0);
    @(negedge clk_core);
    check("w1_start_c3", 32'(st_v[0]), 1);
    check("w1_word", 32'(word_v[0]), 32'h5ABC);
    check("w1_ach", 32'(ach_v[0]), 5);
    check("w1_pending_clr", 32'(pend_v[0]), 0);
    wait_pulses(p0 + 1, 300, "w1_ldac_seen");
    check("w1_ldac_width", 32'(ldac_width[0]), 4);
    check("w1_frames", 32'(frame_n[0] - f0), 1);
    check("w1_pending_end", 32'(pend_v[0]), 0);

    // Three writes in one idle window: round-robin order, single LDAC.
    do_reset();
    f0 = frame_n[0]; p0 = ldac_pulses[0];
    write_ch(1, 'h111);
    write_ch(6, 'h666);
    write_ch(3, 'h333);
    wait_pulses(p0 + 1, 600, "rr_ldac_seen");
    repeat (50) @(negedge clk_core);
    check("rr_frames", 32'(frame_n[0] - f0), 3);
    check("rr_word0", 32'(word_log[0][f0]), 32'h1111);
    check("rr_word1", 32'(word_log[0][f0 + 1]), 32'h3333);
    check("rr_word2", 32'(word_log[0][f0 + 2]), 32'h6666);
    check("rr_one_ldac", 32'(ldac_pulses[0] - p0), 1);
    check("rr_ldac_width", 32'(ldac_width[0]), 4);

    // Rewrite of the in-flight channel is sent again afterwards.
    do_reset();
    f0 = frame_n[0]; p0 = ldac_pulses[0];
    write_ch(2, 'h100);
    wait_in_wait("rw_reach_wait");
    write_ch(2, 'h200);
    check("rw_pending_set", 32'(pend_v[0]), 32'h04);
    check("rw_inflight_word", 32'(word_v[0]), 32'h2100);
    repeat (20) @(negedge clk_core);
    check("rw_pending_in_gap", 32'(pend_v[0]), 32'h04);
    wait_frames(0, f0 + 2, 200, "rw_second_frame");
    check("rw_word0", 32'(word_log[0][f0]), 32'h2100);
    check("rw_word1", 32'(word_log[0][f0 + 1]), 32'h2200);
    wait_pulses(p0 + 1, 300, "rw_ldac_seen");
    repeat (50) @(negedge clk_core);
    check("rw_one_ldac", 32'(ldac_pulses[0] - p0), 1);

    // Serializer never goes busy: timeout, retry, sticky flag.
    do_reset();
    resp_en[0] = 1'b0;
    f0 = frame_n[0];
    write_ch(4, 'h0FF);
    @(negedge clk_core);
    @(negedge clk_core);
    check("to_start", 32'(st_v[0]), 1);
    repeat (1023) @(negedge clk_core);
    check("to_err_before", 32'(err_v[0]), 0);
    check("to_start_held", 32'(st_v[0]), 1);
    @(negedge clk_core);
    check("to_err_set", 32'(err_v[0]), 1);
    check("to_start_drop", 32'(st_v[0]), 0);
    check("to_pending_retry", 32'(pend_v[0]), 32'h10);
    wait_frames(0, f0 + 2, 200, "to_retry_frame");
    check("to_retry_word", 32'(word_log[0][f0 + 1]), 32'h40FF);
    check("to_err_sticky", 32'(err_v[0]), 1);
    resp_en[0] = 1'b1;
    do_reset();

    // Reset asserted while a frame is in WAIT.
    write_ch(7, 'h777);
    wait_in_wait("rs_reach_wait");
    write_ch(0, 'h0AA);
    check("rs_pending_pre", 32'(pend_v[0]), 32'h01);
    @(negedge clk_core) rst = 1'b1;
    #1;
    check_reset_state("rs_mid");
    @(negedge clk_core) rst = 1'b0;
    f0 = frame_n[0];
    repeat (100) @(negedge clk_core);
    check("rs_no_frame", 32'(frame_n[0] - f0), 0);
    check("rs_start_idle", 32'(st_v[0]), 0);
    check("rs_pending_idle", 32'(pend_v[0]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
